// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the SysID slave (word 0 = ID,
// word 1 = build timestamp) once after every reset and again on each start
// pulse, compares both words against compile-time constants and holds the
// pass/fail flags and the raw words until the next check.
//
// Optional build macro SYSID_CHECK_RETRY_EN: when defined, a mismatching
// check (no timeout) is re-run from word 0 up to two more times before done.

module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1618172782,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_AUTO,
        S_IDLE,
        S_REQ,
        S_LAT,
        S_CMP,
        S_FIN
    } state_t;

    // Stall count at which the current read is abandoned (the TIMEOUT_CYCLES-th stall).
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    // Latency counter reload: LAT captures when the counter has run down to zero.
    localparam logic [1:0]  LAT_RELOAD  = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    state_t      state;
    logic [15:0] stall_cnt;
    logic [1:0]  lat_cnt;
    logic        ts_match;
`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0]  retry_cnt;
`endif

    // Word 1 compare against the value captured by the previous state.
    assign ts_match = (ts_value == EXPECTED_TS);

    // Single sequential FSM; every output is a register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the captured words are reset too, so an aborted read never leaves a partial result visible.
        if (!reset_n) begin
            state       <= S_AUTO;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            stall_cnt   <= '0;
            lat_cnt     <= '0;
`ifdef SYSID_CHECK_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_AUTO: begin
                    avm_address <= 1'b0;
                    avm_read    <= 1'b1;
                    stall_cnt   <= '0;
                    busy        <= 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_cnt   <= '0;
`endif
                    state       <= S_REQ;
                end

                S_IDLE: begin
                    if (start) begin
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                        avm_address <= 1'b0;
                        avm_read    <= 1'b1;
                        stall_cnt   <= '0;
                        busy        <= 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
                        retry_cnt   <= '0;
`endif
                        state       <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        lat_cnt  <= LAT_RELOAD;
                        if (READ_LATENCY == 0) begin
                            if (avm_address) ts_value <= avm_readdata;
                            else             id_value <= avm_readdata;
                            state <= S_CMP;
                        end else begin
                            state <= S_LAT;
                        end
                    end else if (stall_cnt == STALL_LIMIT) begin
                        timeout_err <= 1'b1;
                        avm_read    <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_FIN;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end

                S_LAT: begin
                    if (lat_cnt == 2'd0) begin
                        if (avm_address) ts_value <= avm_readdata;
                        else             id_value <= avm_readdata;
                        state <= S_CMP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end

                S_CMP: begin
                    // NOTE: non-blocking updates mean id_value/ts_value here are the words captured last cycle.
                    if (!avm_address) begin
                        id_ok       <= (id_value == EXPECTED_ID);
                        avm_address <= 1'b1;
                        avm_read    <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= S_REQ;
                    end else begin
                        ts_ok <= ts_match;
`ifdef SYSID_CHECK_RETRY_EN
                        if (!(id_ok && ts_match) && (retry_cnt != 2'd2)) begin
                            retry_cnt   <= retry_cnt + 2'd1;
                            avm_address <= 1'b0;
                            avm_read    <= 1'b1;
                            stall_cnt   <= '0;
                            state       <= S_REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
`else
                        done  <= 1'b1;
                        state <= S_FIN;
`endif
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: three sysid_checker instances (READ_LATENCY 1, 0, 3, all
// with TIMEOUT_CYCLES = 4) run the same randomized checks against per-instance
// SysID slave models. Expected results come from a behavioural model and are
// queued per instance; each instance's monitor pops and compares on done.

module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1618172782;
    localparam int          TMO    = 4;
    localparam int          PERIOD = 10;
`ifdef SYSID_CHECK_RETRY_EN
    localparam int          MAX_ATT = 3;
`else
    localparam int          MAX_ATT = 1;
`endif

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] id_val;
        logic [31:0] ts_val;
        int          reads;
        int          attempts;
        bit          timed;
    } exp_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;

    logic [31:0] sc_w0     = EXP_ID;
    logic [31:0] sc_w1     = EXP_TS;
    int          sc_stall0 = 0;
    int          sc_stall1 = 0;
    bit          sc_stuck  = 1'b0;

    logic [31:0] prev_id = '0;
    logic [31:0] prev_ts = '0;
    time         t_start = 0;
    exp_t        exp_next;
    event        push_ev;
    event        flush_ev;

    int n_checks = 0;
    int n_fail   = 0;

    wire [2:0] busy_v;
    wire [2:0] rd_v;
    wire [2:0] addr_v;

    always #(PERIOD / 2) clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Behavioural expectation for one check, straight from the rules:
    // a stuck slave times out on word 0 leaving the old words; otherwise both
    // words are captured, and a mismatch costs MAX_ATT attempts of two reads.
    function automatic exp_t model(input logic [31:0] w0, input logic [31:0] w1,
                                   input bit stuck, input bit timed);
        exp_t e;
        if (stuck) begin
            e.id_ok    = 1'b0;
            e.ts_ok    = 1'b0;
            e.tmo      = 1'b1;
            e.id_val   = prev_id;
            e.ts_val   = prev_ts;
            e.reads    = 0;
            e.attempts = 1;
            e.timed    = 1'b0;
        end else begin
            e.id_ok    = (w0 == EXP_ID);
            e.ts_ok    = (w1 == EXP_TS);
            e.tmo      = 1'b0;
            e.id_val   = w0;
            e.ts_val   = w1;
            e.attempts = (e.id_ok && e.ts_ok) ? 1 : MAX_ATT;
            e.reads    = 2 * e.attempts;
            e.timed    = timed;
            prev_id    = w0;
            prev_ts    = w1;
        end
        return e;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

        logic        avm_address;
        logic        avm_read;
        logic        avm_waitrequest = 1'b0;
        logic [31:0] avm_readdata    = '0;
        logic        busy;
        logic        done;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout_err;
        logic [31:0] id_value;
        logic [31:0] ts_value;

        exp_t        exp_q[$];
        int          pend       = -1;
        logic [31:0] pend_data  = '0;
        int          stall_left = 0;
        logic        rd_prev    = 1'b0;
        logic        addr_prev  = 1'b0;
        logic        done_prev  = 1'b0;
        int          reads      = 0;

        sysid_checker #(
            .EXPECTED_ID    (EXP_ID),
            .EXPECTED_TS    (EXP_TS),
            .READ_LATENCY   (L),
            .TIMEOUT_CYCLES (TMO)
        ) u_dut (
            .clock           (clock),
            .reset_n         (reset_n),
            .start           (start),
            .avm_address     (avm_address),
            .avm_read        (avm_read),
            .avm_readdata    (avm_readdata),
            .avm_waitrequest (avm_waitrequest),
            .busy            (busy),
            .done            (done),
            .id_ok           (id_ok),
            .ts_ok           (ts_ok),
            .timeout_err     (timeout_err),
            .id_value        (id_value),
            .ts_value        (ts_value)
        );

        assign busy_v[gi] = busy;
        assign rd_v[gi]   = avm_read;
        assign addr_v[gi] = avm_address;

        always @(push_ev) exp_q.push_back(exp_next);

        always @(flush_ev) begin
            check($sformatf("L%0d_missing_done", L), 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        // Reset aborts the pending check and must clear every output at once.
        always @(negedge reset_n) begin
            exp_q.delete();
            #1;
            check($sformatf("L%0d_reset_ctrl", L),
                  32'({avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err}), 32'd0);
            check($sformatf("L%0d_reset_id_value", L), id_value, 32'd0);
            check($sformatf("L%0d_reset_ts_value", L), ts_value, 32'd0);
        end

        // Monitor then slave model, evaluated on the falling edge.
        always @(negedge clock) begin
            if (!reset_n) begin
                pend            = -1;
                stall_left      = 0;
                rd_prev         = 1'b0;
                addr_prev       = 1'b0;
                done_prev       = 1'b0;
                reads           = 0;
                avm_waitrequest = 1'b0;
                avm_readdata    = $urandom;
            end else begin
                if (rd_prev && avm_read)
                    check($sformatf("L%0d_addr_stable", L), 32'(avm_address), 32'(addr_prev));
                if (done) begin
                    exp_t e;
                    check($sformatf("L%0d_done_one_cycle", L), 32'(done_prev), 32'd0);
                    check($sformatf("L%0d_busy_at_done", L), 32'(busy), 32'd1);
                    check($sformatf("L%0d_done_expected", L), 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("L%0d_id_ok", L), 32'(id_ok), 32'(e.id_ok));
                        check($sformatf("L%0d_ts_ok", L), 32'(ts_ok), 32'(e.ts_ok));
                        check($sformatf("L%0d_timeout_err", L), 32'(timeout_err), 32'(e.tmo));
                        check($sformatf("L%0d_id_value", L), id_value, e.id_val);
                        check($sformatf("L%0d_ts_value", L), ts_value, e.ts_val);
                        check($sformatf("L%0d_reads", L), 32'(reads), 32'(e.reads));
                        if (e.timed)
                            check($sformatf("L%0d_latency_bound", L),
                                  32'((($time - t_start) / PERIOD) <= e.attempts * (2 * (L + 3) + 1)),
                                  32'd1);
                    end
                    reads = 0;
                end
                done_prev = done;

                if (avm_read && !rd_prev)
                    stall_left = avm_address ? sc_stall1 : sc_stall0;
                if (sc_stuck) begin
                    avm_waitrequest = 1'b1;
                end else if (avm_read && stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                end
                if (avm_read && !avm_waitrequest) begin
                    pend      = L;
                    pend_data = avm_address ? sc_w1 : sc_w0;
                    reads++;
                end
                avm_readdata = (pend == 0) ? pend_data : $urandom;
                if (pend >= 0) pend--;
                rd_prev   = avm_read;
                addr_prev = avm_address;
            end
        end
    end

    task automatic wait_idle();
        int n;
        repeat (3) @(negedge clock);
        n = 0;
        while (busy_v != 3'b000 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", 32'(busy_v), 32'd0);
        -> flush_ev;
        @(negedge clock);
    endtask

    task automatic run_check(input logic [31:0] w0, input logic [31:0] w1,
                             input int s0, input int s1, input bit stuck);
        sc_w0     = w0;
        sc_w1     = w1;
        sc_stall0 = s0;
        sc_stall1 = s1;
        sc_stuck  = stuck;
        exp_next  = model(w0, w1, stuck, (s0 == 0) && (s1 == 0) && !stuck);
        -> push_ev;
        start   = 1'b1;
        t_start = $time;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #(PERIOD * 50000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;
        int          n;

        // Power-on reset followed by the automatic check.
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        prev_id  = '0;
        prev_ts  = '0;
        exp_next = model(EXP_ID, EXP_TS, 1'b0, 1'b0);
        -> push_ev;
        @(negedge clock);
        reset_n = 1'b1;
        wait_idle();

        // Directed: timestamp mismatch, stalled word 0, stuck slave, pass.
        run_check(EXP_ID, 32'h1234_5678, 0, 0, 1'b0);
        run_check(EXP_ID, EXP_TS, 3, 0, 1'b0);
        run_check(EXP_ID, EXP_TS, 0, 0, 1'b1);
        run_check(EXP_ID, EXP_TS, 0, 0, 1'b0);
        run_check(32'hDEAD_BEEF, EXP_TS, 1, 2, 1'b0);

        // Reset while the latency-3 instance waits for word 1.
        sc_w0     = EXP_ID;
        sc_w1     = EXP_TS;
        sc_stall0 = 0;
        sc_stall1 = 0;
        sc_stuck  = 1'b0;
        exp_next  = model(EXP_ID, EXP_TS, 1'b0, 1'b0);
        -> push_ev;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(rd_v[2] && addr_v[2]) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("word1_read_seen", 32'(rd_v[2] && addr_v[2]), 32'd1);
        @(negedge clock);
        #1 reset_n = 1'b0;
        @(negedge clock);
        prev_id  = '0;
        prev_ts  = '0;
        exp_next = model(EXP_ID, EXP_TS, 1'b0, 1'b0);
        -> push_ev;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        // Randomized checks.
        for (int i = 0; i < 16; i++) begin
            w0 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
            w1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS;
            run_check(w0, w1, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
